song_reader: RTL and testbench

//  Sequencer for song_rom (128 x 12b, 4 songs x 32 entries, entry = {note[11:6], duration[5:0]}).

---
 rtl/song_reader.sv | 150 +++++++++++++++
 tb/tb_song_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: walks one song of song_rom and presents each note to the player.
// Define SONG_READER_LOOP_EN to restart the song at its end instead of stopping.
module song_reader #(
  parameter int ADDR_W = 7,
  parameter int SONG_W = 2,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  input  logic                    beat,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_dout,
  output logic [NOTE_W-1:0]       note,
  output logic                    new_note,
  output logic                    note_active,
  output logic                    song_done
);

  localparam int IDX_W = ADDR_W - SONG_W;
  localparam logic [DUR_W-1:0] DUR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [SONG_W-1:0]   r_cur_song;
  logic [IDX_W-1:0]    r_idx;
  logic [DUR_W-1:0]    r_dur;
  logic [NOTE_W-1:0]   r_note;
  logic                r_new_note;
  logic                r_note_active;
  logic                r_song_done;

  logic [NOTE_W-1:0]   w_rom_note;
  logic [DUR_W-1:0]    w_rom_dur;
  logic                w_song_chg;
  logic                w_last_idx;

  assign w_rom_note = rom_dout[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur  = rom_dout[DUR_W-1:0];
  assign w_song_chg = (r_state != S_IDLE) && (song != r_cur_song);
  assign w_last_idx = &r_idx;

  // Song bits only move on a song change, so the address never wraps.
  assign rom_addr    = {r_cur_song, r_idx};
  assign note        = r_note;
  assign new_note    = r_new_note;
  assign note_active = r_note_active;
  assign song_done   = r_song_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cur_song    <= '0;
      r_idx         <= '0;
      r_dur         <= '0;
      r_note        <= '0;
      r_new_note    <= 1'b0;
      r_note_active <= 1'b0;
      r_song_done   <= 1'b0;
    end else begin
      r_new_note <= 1'b0;
`ifdef SONG_READER_LOOP_EN
      r_song_done <= 1'b0;
`endif
      if (w_song_chg) begin
        r_state       <= S_FETCH;
        r_cur_song    <= song;
        r_idx         <= '0;
        r_dur         <= '0;
        r_note_active <= 1'b0;
        r_song_done   <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (play) begin
              r_state    <= S_FETCH;
              r_cur_song <= song;
              r_idx      <= '0;
            end
          end
          S_FETCH: begin
            r_state <= S_LOAD;
          end
          S_LOAD: begin
            if (w_rom_dur == '0) begin
              r_note        <= '0;
              r_note_active <= 1'b0;
              r_song_done   <= 1'b1;
`ifdef SONG_READER_LOOP_EN
              r_state       <= S_FETCH;
              r_idx         <= '0;
`else
              r_state       <= S_DONE;
`endif
            end else begin
              r_note        <= w_rom_note;
              r_dur         <= w_rom_dur;
              r_new_note    <= 1'b1;
              r_note_active <= play && (w_rom_note != '0);
              r_state       <= S_PLAY;
            end
          end
          S_PLAY: begin
            // Paused: counter frozen, beats ignored, note held.
            r_note_active <= play && (r_note != '0);
            if (play && beat) begin
              if (r_dur == DUR_ONE) begin
                r_note_active <= 1'b0;
                if (w_last_idx) begin
                  r_note      <= '0;
                  r_song_done <= 1'b1;
`ifdef SONG_READER_LOOP_EN
                  r_state     <= S_FETCH;
                  r_idx       <= '0;
`else
                  r_state     <= S_DONE;
`endif
                end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_FETCH;
                end
              end else begin
                r_dur <= r_dur - 1'b1;
              end
            end
          end
          S_DONE: begin
            if (!play) begin
              r_state     <= S_IDLE;
              r_song_done <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed checks of song_reader against a small song_rom model.
// Stimulus drives and samples on the falling clock edge.
module tb_song_reader;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        beat;
  logic [6:0]  rom_addr;
  logic [11:0] rom_dout;
  logic [5:0]  note;
  logic        new_note;
  logic        note_active;
  logic        song_done;

  int n_tests;
  int n_fail;

  song_reader dut (
    .clk         (clk),
    .reset       (reset),
    .play        (play),
    .song        (song),
    .beat        (beat),
    .rom_addr    (rom_addr),
    .rom_dout    (rom_dout),
    .note        (note),
    .new_note    (new_note),
    .note_active (note_active),
    .song_done   (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] rom_word(input logic [6:0] a);
    logic [4:0] e;
    logic [5:0] n;
    logic [5:0] d;
    e = a[4:0];
    n = 6'd1;
    d = 6'd1;
    case (a[6:5])
      2'd0: begin
        if (e == 5'd0) begin n = 6'd49; d = 6'd12; end
        else if (e == 5'd1) begin n = 6'd1; d = 6'd8; end
        else if (e == 5'd2) begin n = 6'd0; d = 6'd1; end
        else if (e < 5'd28) begin n = {1'b0, e}; d = 6'd1; end
        else begin n = 6'd0; d = 6'd0; end
      end
      2'd1: begin
        if (e == 5'd0) begin n = 6'd35; d = 6'd36; end
        else if (e == 5'd1) begin n = 6'd20; d = 6'd4; end
        else begin n = 6'd10; d = 6'd2; end
      end
      2'd2: begin
        if (e == 5'd0) begin n = 6'd43; d = 6'd5; end
        else begin n = 6'd7; d = 6'd2; end
      end
      default: begin
        n = {1'b0, e} + 6'd20;
        d = 6'd1;
      end
    endcase
    return {n, d};
  endfunction

  always @(posedge clk) rom_dout <= rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic give_beats(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) beat = 1'b1;
      @(negedge clk) beat = 1'b0;
    end
  endtask

  task automatic wait_nn(input string tag, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = new_note;
    end
    check({tag, "_nn"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    play  = 1'b0;
    song  = 2'd0;
    beat  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_note", 32'(note), 32'd0);
    check("rst_nn", 32'(new_note), 32'd0);
    check("rst_act", 32'(note_active), 32'd0);
    check("rst_done", 32'(song_done), 32'd0);
    reset = 1'b0;

    // 1: first notes of song 0
    @(negedge clk) play = 1'b1;
    wait_nn("t1a", lat);
    check("t1_lat", 32'(lat), 32'd3);
    check("t1_addr0", 32'(rom_addr), 32'd0);
    check("t1_note49", 32'(note), 32'd49);
    check("t1_act", 32'(note_active), 32'd1);
    give_beats(11);
    check("t1_hold", 32'(rom_addr), 32'd0);
    give_beats(1);
    check("t1_addr1", 32'(rom_addr), 32'd1);
    wait_nn("t1b", lat);
    check("t1_note1", 32'(note), 32'd1);
    give_beats(7);
    check("t1_hold1", 32'(rom_addr), 32'd1);
    give_beats(1);
    check("t1_addr2", 32'(rom_addr), 32'd2);

    // 2: rest of song 0 up to the end marker at entry 28
    for (int e = 2; e < 28; e++) begin
      wait_nn("t2", lat);
      check("t2_note", 32'(note), (e == 2) ? 32'd0 : 32'(e));
      if (e == 2) check("t2_rest", 32'(note_active), 32'd0);
      give_beats(1);
    end
    repeat (3) @(negedge clk);
    check("t2_done", 32'(song_done), 32'd1);
    check("t2_note0", 32'(note), 32'd0);
    check("t2_act0", 32'(note_active), 32'd0);
    check("t2_addr28", 32'(rom_addr), 32'd28);
    play = 1'b0;
    repeat (2) @(negedge clk);
    check("t2_undone", 32'(song_done), 32'd0);

    // 3: pause mid-note in song 1
    song = 2'd1;
    play = 1'b1;
    wait_nn("t3", lat);
    check("t3_note35", 32'(note), 32'd35);
    give_beats(10);
    play = 1'b0;
    give_beats(50);
    check("t3_held", 32'(note), 32'd35);
    check("t3_act0", 32'(note_active), 32'd0);
    check("t3_addr32", 32'(rom_addr), 32'd32);
    play = 1'b1;
    give_beats(25);
    check("t3_pre", 32'(rom_addr), 32'd32);
    give_beats(1);
    check("t3_addr33", 32'(rom_addr), 32'd33);

    // 4: song switch on the same edge as a terminal beat
    wait_nn("t4a", lat);
    check("t4_note20", 32'(note), 32'd20);
    give_beats(3);
    @(negedge clk);
    beat = 1'b1;
    song = 2'd2;
    @(negedge clk) beat = 1'b0;
    check("t4_addr64", 32'(rom_addr), 32'd64);
    wait_nn("t4b", lat);
    check("t4_note43", 32'(note), 32'd43);

    // 5: song 3 played through its last entry
    @(negedge clk) song = 2'd3;
    for (int e = 0; e < 32; e++) begin
      wait_nn("t5", lat);
      check("t5_note", 32'(note), 32'(e + 20));
      give_beats(1);
    end
    check("t5_done", 32'(song_done), 32'd1);
    check("t5_act0", 32'(note_active), 32'd0);
`ifdef SONG_READER_LOOP_EN
    check("t5_addr96", 32'(rom_addr), 32'd96);
    @(negedge clk);
    check("t5_pulse", 32'(song_done), 32'd0);
`else
    check("t5_addr127", 32'(rom_addr), 32'd127);
    check("t5_note0", 32'(note), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_level", 32'(song_done), 32'd1);
    check("t5_stay", 32'(rom_addr), 32'd127);
`endif
    play = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_undone", 32'(song_done), 32'd0);

    // 6: asynchronous reset in the middle of a note
    song = 2'd0;
    play = 1'b1;
    wait_nn("t6a", lat);
    give_beats(3);
    check("t6_pre", 32'(note_active), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_addr", 32'(rom_addr), 32'd0);
    check("t6_note", 32'(note), 32'd0);
    check("t6_act", 32'(note_active), 32'd0);
    check("t6_done", 32'(song_done), 32'd0);
    @(negedge clk) reset = 1'b0;
    wait_nn("t6b", lat);
    check("t6_addr0", 32'(rom_addr), 32'd0);
    check("t6_note49", 32'(note), 32'd49);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
